// File: rtl/mwa_pkg.sv
// Shared encodings for the multi-precision add/sub sequencer.
// Operation codes, arithmetic-unit func codes and FSM states.
package mwa_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_e;

  localparam logic [2:0] FUNC_ADD  = 3'b010;
  localparam logic [2:0] FUNC_SUB  = 3'b011;
  localparam logic [2:0] FUNC_INC  = 3'b000;
  localparam logic [2:0] FUNC_DEC  = 3'b001;
  localparam logic [2:0] FUNC_ADDC = 3'b110;
  localparam logic [2:0] FUNC_CIN  = 3'b100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FLAG = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Sub and dec report the inverse of the unit's carry (carry=1 is no borrow).
  function automatic logic is_borrow_op(input op_e op);
    return op == OP_SUB || op == OP_DEC;
  endfunction

endpackage

// File: rtl/mwa_word_sel.sv
// Per-cycle operand/func selection toward the 32-bit arithmetic unit.
// Word 0 seeds the carry chain; later words ride the unit's carry register.
module mwa_word_sel
  import mwa_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int KW    = 2
) (
  input  logic [1:0]             state,
  input  op_e                    op,
  input  logic [KW-1:0]          k,
  input  logic [WORDS-1:0][31:0] a,
  input  logic [WORDS-1:0][31:0] b,
  output logic [31:0]            left,
  output logic [31:0]            right,
  output logic [2:0]             func
);

  always_comb begin
    left  = '0;
    right = '0;
    func  = FUNC_ADD;
    unique case (state)
      RUN: begin
        left = a[k];
        if (k == '0) begin
          unique case (op)
            OP_ADD: begin func = FUNC_ADD; right = b[0]; end
            OP_SUB: begin func = FUNC_SUB; right = b[0]; end
            OP_INC: func = FUNC_INC;
            OP_DEC: func = FUNC_DEC;
            default: func = FUNC_ADD;
          endcase
        end else begin
          func = FUNC_ADDC;
          unique case (op)
            OP_ADD:  right = b[k];
            OP_SUB:  right = ~b[k];
            OP_INC:  right = '0;
            OP_DEC:  right = '1;
            default: right = '0;
          endcase
        end
      end
      FLAG:    func = FUNC_CIN;
      default: func = FUNC_ADD;
    endcase
  end

endmodule

// File: rtl/multiword_arith_seq.sv
// Multi-precision add/sub/inc/dec sequencer driving a 32-bit arithmetic unit.
// Optional ZERO_FLAG_EN adds a zero flag output zf.
module multiword_arith_seq
  import mwa_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CW    = $clog2(WORDS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [CW-1:0]       nwords,
  input  logic [WORDS*32-1:0] a_in,
  input  logic [WORDS*32-1:0] b_in,
  output logic                busy,
  output logic                done,
  output logic [WORDS*32-1:0] result,
  output logic                cf,
`ifdef ZERO_FLAG_EN
  output logic                zf,
`endif
  output logic [31:0]         alu_left,
  output logic [31:0]         alu_right,
  output logic [2:0]          alu_func,
  input  logic [31:0]         alu_result
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [1:0]             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CW-1:0]          n_q, n_d, n_clamp;
  op_e                    op_q, op_d;
  logic [WORDS-1:0][31:0] a_q, a_d;
  logic [WORDS-1:0][31:0] b_q, b_d;
  logic [WORDS-1:0][31:0] result_q, result_d;
  logic                   cf_q, cf_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   last_word;
`ifdef ZERO_FLAG_EN
  logic                   nz_q, nz_d;
  logic                   zf_q, zf_d;
`endif

  always_comb begin
    n_clamp = nwords;
    if (nwords == '0 || nwords > CW'(WORDS)) n_clamp = CW'(WORDS);
  end

  assign last_word = CW'(k_q) == n_q - CW'(1);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cf_d     = cf_q;
    done_d   = 1'b0;
`ifdef ZERO_FLAG_EN
    nz_d     = nz_q;
    zf_d     = zf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op_e'(op);
          n_d      = n_clamp;
          a_d      = a_in;
          b_d      = b_in;
          k_d      = '0;
          result_d = '0;
`ifdef ZERO_FLAG_EN
          nz_d     = 1'b0;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[k_q] = alu_result;
`ifdef ZERO_FLAG_EN
        nz_d = nz_q | (|alu_result);
`endif
        if (last_word) state_d = FLAG;
        else           k_d     = k_q + KW'(1);
      end
      FLAG: begin
        cf_d    = alu_result[0] ^ is_borrow_op(op_q);
`ifdef ZERO_FLAG_EN
        zf_d    = ~nz_q;
`endif
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      n_q      <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
      nz_q     <= 1'b0;
      zf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef ZERO_FLAG_EN
      nz_q     <= nz_d;
      zf_q     <= zf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cf     = cf_q;
`ifdef ZERO_FLAG_EN
  assign zf     = zf_q;
`endif

  mwa_word_sel #(
    .WORDS(WORDS),
    .KW   (KW)
  ) u_sel (
    .state(state_q),
    .op   (op_q),
    .k    (k_q),
    .a    (a_q),
    .b    (b_q),
    .left (alu_left),
    .right(alu_right),
    .func (alu_func)
  );

endmodule

// File: tb/tb_multiword_arith_seq.sv
// Directed bench for multiword_arith_seq with a model of the 32-bit unit.
// The unit model holds a carry register updated on every clock edge.
module tb_multiword_arith_seq;

  localparam int WORDS = 4;
  localparam int CW    = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         op;
  logic [CW-1:0]      nwords;
  logic [127:0]       a_in;
  logic [127:0]       b_in;
  logic               busy;
  logic               done;
  logic [127:0]       result;
  logic               cf;
`ifdef ZERO_FLAG_EN
  logic               zf;
`endif
  logic [31:0]        alu_left;
  logic [31:0]        alu_right;
  logic [2:0]         alu_func;
  logic [31:0]        alu_result;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multiword_arith_seq #(
    .WORDS(WORDS),
    .CW   (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .nwords    (nwords),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cf        (cf),
`ifdef ZERO_FLAG_EN
    .zf        (zf),
`endif
    .alu_left  (alu_left),
    .alu_right (alu_right),
    .alu_func  (alu_func),
    .alu_result(alu_result)
  );

  logic        carry_q = 1'b0;
  logic [32:0] sum;

  always_comb begin
    sum = '0;
    case (alu_func)
      3'b010: sum = {1'b0, alu_left} + {1'b0, alu_right};
      3'b011: sum = {1'b0, alu_left} + {1'b0, ~alu_right} + 33'd1;
      3'b000: sum = {1'b0, alu_left} + 33'd1;
      3'b001: sum = {1'b0, alu_left} + 33'h0FFFFFFFF;
      3'b110: sum = {1'b0, alu_left} + {1'b0, alu_right} + {32'd0, carry_q};
      3'b100: sum = {1'b0, alu_left} + {32'd0, carry_q};
      default: sum = '0;
    endcase
  end

  assign alu_result = sum[31:0];

  always @(posedge clock) carry_q <= sum[32];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check busy, the first-word drive and done timing.
  task automatic run(input string tag, input logic [1:0] o,
                     input logic [CW-1:0] nw, input logic [127:0] a,
                     input logic [127:0] b, input int n, input bit poke);
    logic [2:0] f0 [4];
    f0 = '{3'b010, 3'b011, 3'b000, 3'b001};
    op     = o;
    nwords = nw;
    a_in   = a;
    b_in   = b;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk({tag, ".busy"}, 128'(busy), 128'd1);
    chk({tag, ".func0"}, 128'(alu_func), 128'(f0[o]));
    chk({tag, ".left0"}, 128'(alu_left), 128'(a[31:0]));
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (poke && i == 0) begin
        start = 1'b1;
        a_in  = '1;
        b_in  = '1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, ".done_early"}, 128'(done), 128'd0);
    @(posedge clock);
    #1;
    chk({tag, ".done"}, 128'(done), 128'd1);
    chk({tag, ".busy_done"}, 128'(busy), 128'd1);
  endtask

  task automatic finish_op(input string tag, input logic [127:0] exp_res,
                           input logic exp_cf);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".cf"}, 128'(cf), 128'(exp_cf));
    @(posedge clock);
    #1;
    chk({tag, ".done_drop"}, 128'(done), 128'd0);
    chk({tag, ".idle"}, 128'(busy), 128'd0);
    chk({tag, ".held"}, result, exp_res);
  endtask

  initial begin
    bit seen_done;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    nwords = '0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst.busy", 128'(busy), 128'd0);
    chk("rst.done", 128'(done), 128'd0);
    chk("rst.result", result, 128'd0);
    chk("rst.cf", 128'(cf), 128'd0);
    chk("rst.func", 128'(alu_func), 128'(3'b010));
    chk("rst.left", 128'(alu_left), 128'd0);
    chk("rst.right", 128'(alu_right), 128'd0);
`ifdef ZERO_FLAG_EN
    chk("rst.zf", 128'(zf), 128'd0);
`endif

    run("add2", 2'b00, 3'd2, 128'h0000_0000_FFFF_FFFF, 128'h1, 2, 1'b0);
    finish_op("add2", 128'h0000_0001_0000_0000, 1'b0);

    run("subA", 2'b01, 3'd2, 128'h0000_0001_0000_0000, 128'h1, 2, 1'b0);
    chk("subA.right0", 128'(alu_right), 128'd0);
    finish_op("subA", 128'h0000_0000_FFFF_FFFF, 1'b0);
    run("subB", 2'b01, 3'd2, 128'h0, 128'h1, 2, 1'b0);
    finish_op("subB", 128'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    run("inc_ones", 2'b10, 3'd4, {128{1'b1}}, 128'h5, 4, 1'b0);
`ifdef ZERO_FLAG_EN
    chk("inc_ones.zf", 128'(zf), 128'd1);
`endif
    finish_op("inc_ones", 128'h0, 1'b1);
    run("inc7", 2'b10, 3'd4, 128'h7, 128'h0, 4, 1'b0);
`ifdef ZERO_FLAG_EN
    chk("inc7.zf", 128'(zf), 128'd0);
`endif
    finish_op("inc7", 128'h8, 1'b0);

    run("dec3", 2'b11, 3'd3, 128'h0, 128'h1234_5678, 3, 1'b0);
    finish_op("dec3", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);

    op     = 2'b00;
    nwords = 3'd4;
    a_in   = 128'h1;
    b_in   = 128'h2;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort.busy", 128'(busy), 128'd0);
    chk("abort.result", result, 128'd0);
    chk("abort.cf", 128'(cf), 128'd0);
    chk("abort.done", 128'(done), 128'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort.no_done", 128'(seen_done), 128'd0);

    run("poke", 2'b00, 3'd4, 128'h1, 128'h2, 4, 1'b1);
    finish_op("poke", 128'h3, 1'b0);

    run("n0", 2'b00, 3'd0, {128{1'b1}}, {128{1'b1}}, 4, 1'b0);
    finish_op("n0", {{124{1'b1}}, 4'hE}, 1'b1);

    run("n7", 2'b10, 3'd7, {128{1'b1}}, 128'h0, 4, 1'b0);
    finish_op("n7", 128'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
